// File: rtl/toggle_handshake_rx.sv
// Receiving end of a two-phase toggle handshake: syncs req_tgl, captures data_in into a
// small FIFO, acks by toggling ack_tgl, and streams words out. Optional: TGL_RX_ERR_EN.
module toggle_handshake_rx #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_tgl,
    input  logic [DW-1:0] data_in,
    output logic          ack_tgl,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [AW:0]   level,
    output logic          err_ovr
);

    typedef enum logic {IDLE, STALL} state_t;

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    state_t        state_q;
    logic          req_s1_q, req_s2_q, seen_q, ack_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d;
    logic [DW-1:0] mem_q [DEPTH];

    logic pending, full, push, pop;

    assign pending = (req_s2_q != seen_q);
    assign full    = (level_q == FULL_LVL);
    // Capture uses the pre-pop full flag, so a pop never lets a word in on the same edge.
    assign push    = pending && !full;
    assign pop     = out_valid && out_ready;

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            req_s1_q <= 1'b0;
            req_s2_q <= 1'b0;
            seen_q   <= 1'b0;
            ack_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            req_s1_q <= req_tgl;
            req_s2_q <= req_s1_q;
            level_q  <= level_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                seen_q   <= req_s2_q;
                ack_q    <= ~ack_q;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case (state_q)
                IDLE:    if (pending && full) state_q <= STALL;
                STALL:   if (push)            state_q <= IDLE;
                default:                      state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign ack_tgl   = ack_q;
    assign out_valid = (level_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign level     = level_q;

`ifdef TGL_RX_ERR_EN
    logic err_q;

    // A second sender toggle arriving while the first is still unacknowledged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (pending && (req_s1_q != req_s2_q)) begin
            err_q <= 1'b1;
        end
    end

    assign err_ovr = err_q;
`else
    assign err_ovr = 1'b0;
`endif

endmodule

// File: tb/tb_toggle_handshake_rx.sv
// Self-checking bench for toggle_handshake_rx: directed protocol cases plus a randomized
// stream checked against an in-order word queue and an occupancy count.
module tb_toggle_handshake_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_tgl;
    logic [7:0] data_in;
    logic       ack_tgl;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [2:0] level;
    logic       err_ovr;

    int n_chk = 0;
    int n_err = 0;
    int n_pop = 0;
    int lvl_m = 0;
    logic ack_prev = 1'b0;
    logic pop_prev = 1'b0;
    logic rnd_mode = 1'b0;
    logic [7:0] exp_q [$];

    toggle_handshake_rx #(.DW(8), .DEPTH(4), .AW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_tgl   (req_tgl),
        .data_in   (data_in),
        .ack_tgl   (ack_tgl),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .level     (level),
        .err_ovr   (err_ovr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Words leave in send order; occupancy = acks seen minus pops taken.
    always @(negedge clk) begin
        if (!rst_n) begin
            lvl_m    = 0;
            ack_prev = 1'b0;
            pop_prev = 1'b0;
        end else begin
            if (ack_tgl !== ack_prev) lvl_m++;
            if (pop_prev) lvl_m--;
            ack_prev = ack_tgl;
            check_eq("level_model", {29'b0, level}, lvl_m);
            pop_prev = out_valid && out_ready;
            if (pop_prev) begin
                if (exp_q.size() == 0) begin
                    check_eq("pop_unexpected", exp_q.size(), 1);
                end else begin
                    check_eq("order", {24'b0, out_data}, {24'b0, exp_q.pop_front()});
                    n_pop++;
                end
            end
        end
    end

    task automatic wait_ack(input string tag);
        int unsigned n = 0;
        while (ack_tgl !== req_tgl && n < 60) begin
            if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        check_eq(tag, {31'b0, ack_tgl}, {31'b0, req_tgl});
    endtask

    task automatic send_word(input logic [7:0] d, input string tag);
        req_tgl = ~req_tgl;
        data_in = d;
        exp_q.push_back(d);
        wait_ack(tag);
    endtask

    task automatic drain(input string tag);
        int unsigned n = 0;
        out_ready = 1'b1;
        while (out_valid && n < 100) begin
            tick();
            n++;
        end
        check_eq(tag, {29'b0, level}, 0);
        out_ready = 1'b0;
    endtask

    initial begin
        logic       ack_hold;
        logic [7:0] d;
        int         pops0;
        logic [31:0] err_exp;
`ifdef TGL_RX_ERR_EN
        err_exp = 1;
`else
        err_exp = 0;
`endif
        rst_n = 1'b0; req_tgl = 1'b0; data_in = '0; out_ready = 1'b0;
        repeat (3) tick();
        check_eq("rst_ack", {31'b0, ack_tgl}, 0);
        check_eq("rst_valid", {31'b0, out_valid}, 0);
        check_eq("rst_level", {29'b0, level}, 0);
        check_eq("rst_err", {31'b0, err_ovr}, 0);
        rst_n = 1'b1;
        tick();

        // single word, k+2 latency
        req_tgl = 1'b1; data_in = 8'hA5; out_ready = 1'b1; exp_q.push_back(8'hA5);
        tick(); tick();
        check_eq("single_ack_early", {31'b0, ack_tgl}, 0);
        tick();
        check_eq("single_ack", {31'b0, ack_tgl}, 1);
        check_eq("single_valid", {31'b0, out_valid}, 1);
        check_eq("single_data", {24'b0, out_data}, 32'hA5);
        check_eq("single_level", {29'b0, level}, 1);
        tick();
        check_eq("single_valid_gone", {31'b0, out_valid}, 0);
        check_eq("single_level_zero", {29'b0, level}, 0);

        // fill, stall, pop releases stalled word one cycle later
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send_word(8'(i), "fill_ack");
        check_eq("fill_level", {29'b0, level}, 4);
        ack_hold = ack_tgl;
        req_tgl = ~req_tgl; data_in = 8'h05; exp_q.push_back(8'h05);
        repeat (6) tick();
        check_eq("stall_ack", {31'b0, ack_tgl}, {31'b0, ack_hold});
        check_eq("stall_level", {29'b0, level}, 4);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("nobypass_ack", {31'b0, ack_tgl}, {31'b0, ack_hold});
        check_eq("nobypass_level", {29'b0, level}, 3);
        check_eq("nobypass_head", {24'b0, out_data}, 32'h02);
        tick();
        check_eq("release_ack", {31'b0, ack_tgl}, {31'b0, req_tgl});
        check_eq("release_level", {29'b0, level}, 4);
        drain("fill_drain");

        // simultaneous push and pop at level 2
        send_word(8'h20, "pp_ack");
        send_word(8'h21, "pp_ack");
        req_tgl = ~req_tgl; data_in = 8'h22; exp_q.push_back(8'h22);
        tick(); tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("pp_level", {29'b0, level}, 2);
        check_eq("pp_ack_done", {31'b0, ack_tgl}, {31'b0, req_tgl});
        check_eq("pp_head", {24'b0, out_data}, 32'h21);
        drain("pp_drain");

        // ordered stream with wrap
        pops0 = n_pop;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) send_word(8'h10 + 8'(i), "stream_ack");
        drain("stream_drain");
        check_eq("stream_count", n_pop - pops0, 10);

        // randomized data, gaps and backpressure
        pops0 = n_pop;
        rnd_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) begin
                out_ready = 1'($urandom_range(0, 1));
                tick();
            end
            d = 8'($urandom);
            send_word(d, "rand_ack");
        end
        rnd_mode = 1'b0;
        drain("rand_drain");
        check_eq("rand_count", n_pop - pops0, 40);
        check_eq("rand_q_empty", exp_q.size(), 0);

        // async reset mid-transfer, req held high out of reset
        send_word(8'h31, "rst_pre_ack");
        send_word(8'h32, "rst_pre_ack");
        req_tgl = ~req_tgl; data_in = 8'h33;
        #2;
        rst_n = 1'b0; req_tgl = 1'b1; data_in = 8'h3C;
        #1;
        check_eq("arst_ack", {31'b0, ack_tgl}, 0);
        check_eq("arst_valid", {31'b0, out_valid}, 0);
        check_eq("arst_level", {29'b0, level}, 0);
        check_eq("arst_err", {31'b0, err_ovr}, 0);
        exp_q.delete();
        tick(); tick();
        rst_n = 1'b1;
        exp_q.push_back(8'h3C);
        wait_ack("held_req_ack");
        check_eq("held_req_data", {24'b0, out_data}, 32'h3C);
        check_eq("held_req_level", {29'b0, level}, 1);
        drain("held_drain");

        // overrun: second toggle while full and unacked
        for (int i = 0; i < 4; i++) send_word(8'h40 + 8'(i), "ovr_fill_ack");
        ack_hold = ack_tgl;
        req_tgl = ~req_tgl; data_in = 8'h55;
        repeat (4) tick();
        check_eq("ovr_before", {31'b0, err_ovr}, 0);
        req_tgl = ~req_tgl;
        repeat (4) tick();
        check_eq("ovr_err", {31'b0, err_ovr}, err_exp);
        repeat (5) tick();
        check_eq("ovr_sticky", {31'b0, err_ovr}, err_exp);
        check_eq("ovr_ack", {31'b0, ack_tgl}, {31'b0, ack_hold});
        check_eq("ovr_level", {29'b0, level}, 4);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_eq("ovr_rst_err", {31'b0, err_ovr}, 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
